// File: rtl/lbnl_hit_pkg.sv
// Shared types for the LBNL pixel ToT counter.
// The hit record layout (ToT and BCID widths) is defined here. Every module
// that stores or moves hit records picks its widths up from this package.
//   HIT_TOT_W : ToT field width; the all-ones code means overflow
//   HIT_TS_W  : BCID timestamp width
//   hit_t     : one queued hit {tot, ts}
//   tot_state_e : ToT measurement FSM states

package lbnl_hit_pkg;

    localparam int HIT_TOT_W = 4;
    localparam int HIT_TS_W  = 9;

    localparam logic [HIT_TOT_W-1:0] TOT_OVF = '1;

    typedef struct packed {
        logic [HIT_TOT_W-1:0] tot;
        logic [HIT_TS_W-1:0]  ts;
    } hit_t;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } tot_state_e;

endpackage

// File: rtl/lbnl_hit_fifo.sv
// First-word-fall-through FIFO of hit records.
// The head record is visible on data_o whenever empty_o is low. A push into a
// full FIFO is accepted when a pop happens in the same cycle, because the pop
// frees the slot the push needs. A push into a full FIFO without a pop is
// ignored; the parent module counts it as a drop.
// Ports:
//   clk     in   clock
//   rst     in   synchronous active-high reset; empties the FIFO
//   push_i  in   write data_i this cycle
//   data_i  in   record to write
//   pop_i   in   remove the head record this cycle (ignored when empty)
//   data_o  out  head record, or zero when empty
//   full_o  out  all DEPTH entries occupied
//   empty_o out  no entries

module lbnl_hit_fifo
    import lbnl_hit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  hit_t data_i,
    input  logic pop_i,
    output hit_t data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);

    hit_t          mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic          pop_ok;
    logic          push_ok;

    // The extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Gating the head with empty keeps the outputs at zero out of reset and
    // after the last pop.
    assign data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/lbnl_pixel_tot_counter.sv
// Digital back end of one LBNL linear front-end pixel.
// Synchronises the active-low discriminator output, measures Time-over-Threshold
// in BX cycles, tags each hit with the BCID of its leading edge and queues it
// for the pixel-region readout.
//
//  state | meaning
//  IDLE  | waiting for a rising edge of act while EN is high
//  COUNT | pulse in progress, tot_q counting BX cycles with act high
//
// Ports:
//   CLK        in   BX clock
//   RESET      in   synchronous active-high reset
//   EN         in   pixel enable
//   outdis     in   discriminator output, low while above threshold, async
//   bcid_i     in   free-running BCID
//   hit_valid  out  head hit record available
//   hit_ready  in   consumer takes the head record when hit_valid && hit_ready
//   hit_tot    out  ToT of head record (all-ones = overflow)
//   hit_ts     out  leading-edge BCID of head record
//   busy       out  FSM is not IDLE
//   drop_cnt   out  hits lost to a full FIFO, saturating
// Record widths come from lbnl_hit_pkg.

module lbnl_pixel_tot_counter
    import lbnl_hit_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 2,
    parameter int DROP_W      = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 EN,
    input  logic                 outdis,
    input  logic [HIT_TS_W-1:0]  bcid_i,
    output logic                 hit_valid,
    input  logic                 hit_ready,
    output logic [HIT_TOT_W-1:0] hit_tot,
    output logic [HIT_TS_W-1:0]  hit_ts,
    output logic                 busy,
    output logic [DROP_W-1:0]    drop_cnt
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] flush_q;
    logic                   armed_q;
    logic                   act;
    logic                   act_q;
    logic                   act_rise;

    tot_state_e             state_q;
    logic [HIT_TOT_W-1:0]   tot_q;
    logic [HIT_TS_W-1:0]    ts_q;

    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    hit_t                   push_rec;
    hit_t                   head_rec;

    logic [DROP_W-1:0]      drop_q;
    logic [DROP_W-1:0]      drop_d;

    // Synchroniser flops reset to the idle (high) level of outdis.
    // flush_q tracks when the chain holds only post-reset samples, so a pulse
    // already in progress across reset cannot be taken as a fresh edge: act
    // must first be seen low from real samples before arming.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_q  <= '1;
            flush_q <= '0;
            armed_q <= 1'b0;
            act_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], outdis};
            flush_q <= {flush_q[SYNC_STAGES-2:0], 1'b1};
            armed_q <= armed_q | (flush_q[SYNC_STAGES-1] & ~act);
            act_q   <= act;
        end
    end

    assign act      = ~sync_q[SYNC_STAGES-1];
    assign act_rise = act && !act_q && armed_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            tot_q   <= '0;
            ts_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (EN && act_rise) begin
                        ts_q    <= bcid_i;
                        tot_q   <= {{(HIT_TOT_W-1){1'b0}}, 1'b1};
                        state_q <= COUNT;
                    end
                end
                COUNT: begin
                    if (!EN) begin
                        state_q <= IDLE;
                    end else if (act) begin
                        if (tot_q != TOT_OVF) begin
                            tot_q <= tot_q + 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The record is written on the same edge the FSM sees the trailing edge.
    assign push     = (state_q == COUNT) && EN && !act;
    assign push_rec = '{tot: tot_q, ts: ts_q};
    assign pop      = hit_valid && hit_ready;

    lbnl_hit_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RESET),
        .push_i  (push),
        .data_i  (push_rec),
        .pop_i   (pop),
        .data_o  (head_rec),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        drop_d = drop_q;
        if (push && fifo_full && !pop && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign hit_valid = !fifo_empty;
    assign hit_tot   = head_rec.tot;
    assign hit_ts    = head_rec.ts;
    assign busy      = (state_q != IDLE);
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_lbnl_pixel_tot_counter.sv
module tb_lbnl_pixel_tot_counter;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       EN;
    logic       outdis;
    logic [8:0] bcid_i;
    logic       hit_valid;
    logic       hit_ready;
    logic [3:0] hit_tot;
    logic [8:0] hit_ts;
    logic       busy;
    logic [7:0] drop_cnt;

    always #5 CLK = ~CLK;

    lbnl_pixel_tot_counter dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .EN        (EN),
        .outdis    (outdis),
        .bcid_i    (bcid_i),
        .hit_valid (hit_valid),
        .hit_ready (hit_ready),
        .hit_tot   (hit_tot),
        .hit_ts    (hit_ts),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    // Reference model: pulses become expected records scheduled for the edge
    // at which the hit must enter the queue; the queue has two slots.
    typedef struct {
        int at;
        int tot;
        int ts;
    } rec_t;

    localparam int DEPTH   = 2;
    localparam int OVF     = 15;
    localparam int CAP_LAT = 2;   // edges from first low sample to BCID capture

    rec_t pend[$];
    rec_t mq[$];
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   cyc      = 0;
    int   drop_exp = 0;
    int   rdy_edge = -1;
    bit   rand_rdy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit   pop;
        bit   push;
        rec_t r;
        if (rand_rdy) hit_ready = 1'($urandom_range(0, 1));
        if (cyc == rdy_edge) hit_ready = 1'b1;
        pop  = (mq.size() > 0) && hit_ready && !RESET;
        push = (pend.size() > 0) && (pend[0].at == cyc) && !RESET;
        @(posedge CLK);
        #1;
        if (RESET) begin
            mq.delete();
            pend.delete();
            drop_exp = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                r = pend.pop_front();
                if (mq.size() < DEPTH) mq.push_back(r);
                else if (drop_exp < 255) drop_exp++;
            end
        end
        cyc++;
        bcid_i = bcid_i + 9'd1;
        chk("valid", 32'(hit_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("head_tot", 32'(hit_tot), 32'(mq[0].tot));
            chk("head_ts", 32'(hit_ts), 32'(mq[0].ts));
        end
        chk("drop_cnt", 32'(drop_cnt), 32'(drop_exp));
    endtask

    // Low for n cycles then high for gap cycles; sched=1 when the pulse must yield a hit.
    task automatic pulse(input int n, input int gap, input bit sched);
        rec_t r;
        if (sched) begin
            r.at  = cyc + n + CAP_LAT;
            r.tot = (n > OVF) ? OVF : n;
            r.ts  = (int'(bcid_i) + CAP_LAT) % 512;
            pend.push_back(r);
        end
        outdis = 1'b0;
        repeat (n) step();
        outdis = 1'b1;
        repeat (gap) step();
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        repeat (2) step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(hit_valid), 32'd0);
        chk("rst_tot", 32'(hit_tot), 32'd0);
        chk("rst_ts", 32'(hit_ts), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        RESET = 1'b0;
    endtask

    initial begin
        RESET     = 1'b1;
        EN        = 1'b1;
        outdis    = 1'b1;
        hit_ready = 1'b1;
        bcid_i    = 9'd0;
        do_reset();
        repeat (4) step();

        // 1: 5-cycle pulse, BCID 0x023 at capture, valid one cycle after trailing edge
        bcid_i = 9'h021;
        pulse(5, 0, 1'b1);
        outdis = 1'b1;
        step();
        step();
        chk("t1_valid_early", 32'(hit_valid), 32'd0);
        step();
        chk("t1_valid", 32'(hit_valid), 32'd1);
        chk("t1_tot", 32'(hit_tot), 32'd5);
        chk("t1_ts", 32'(hit_ts), 32'h023);
        repeat (3) step();

        // 2: 20-cycle pulse saturates at the overflow code
        pulse(20, 4, 1'b1);
        repeat (3) step();

        // 3: consumer stalled, three pulses, third is dropped
        hit_ready = 1'b0;
        pulse(3, 2, 1'b1);
        pulse(3, 2, 1'b1);
        pulse(3, 2, 1'b1);
        repeat (3) step();
        chk("t3_drop", 32'(drop_cnt), 32'd1);
        chk("t3_valid", 32'(hit_valid), 32'd1);
        hit_ready = 1'b1;
        repeat (4) step();

        // 4: EN falls during the pulse, then a pulse already present when EN rises
        outdis = 1'b0;
        repeat (3) step();
        chk("t4_busy_cnt", 32'(busy), 32'd1);
        EN = 1'b0;
        step();
        chk("t4_busy_abort", 32'(busy), 32'd0);
        EN = 1'b1;
        repeat (2) step();
        outdis = 1'b1;
        repeat (5) step();
        EN = 1'b0;
        outdis = 1'b0;
        repeat (4) step();
        EN = 1'b1;
        repeat (3) step();
        chk("t4_busy_late", 32'(busy), 32'd0);
        outdis = 1'b1;
        repeat (5) step();

        // 5: reset during COUNT with one hit queued
        hit_ready = 1'b0;
        pulse(4, 3, 1'b1);
        outdis = 1'b0;
        repeat (4) step();
        chk("t5_busy", 32'(busy), 32'd1);
        do_reset();
        repeat (3) step();
        outdis = 1'b1;
        repeat (6) step();
        hit_ready = 1'b1;
        pulse(2, 4, 1'b1);

        // 6: FIFO full, ready rises on exactly the pushing edge
        hit_ready = 1'b0;
        pulse(2, 2, 1'b1);
        pulse(3, 2, 1'b1);
        rdy_edge = cyc + 4 + CAP_LAT;
        pulse(4, 6, 1'b1);
        rdy_edge = -1;
        chk("t6_drop", 32'(drop_cnt), 32'd0);

        // forced drops until the counter saturates
        hit_ready = 1'b0;
        repeat (302) pulse(1, 2, 1'b1);
        repeat (3) step();
        chk("sat_drop", 32'(drop_cnt), 32'd255);
        hit_ready = 1'b1;
        repeat (4) step();

        // random pulses and random back-pressure against the model
        do_reset();
        repeat (4) step();
        rand_rdy = 1'b1;
        for (int i = 0; i < 80; i++) begin
            pulse(int'($urandom_range(1, 20)), int'($urandom_range(1, 5)), 1'b1);
        end
        rand_rdy  = 1'b0;
        hit_ready = 1'b1;
        repeat (6) step();
        chk("end_valid", 32'(hit_valid), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
